pool_window_ctrl: RTL

Frame sequencer for the max-pooling datapath. It accepts a raster-order pixel stream (column fastest, then row, then channel) for C feature maps of N rows by M columns. It tracks window position and gates the stream into the pooling unit, and it flags the pixel that completes each non-overlapping PxP window. It also delays that flag to match the pooling unit's output latency and signals frame completion once the pipeline has drained.

---
 rtl/pool_window_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/pool_window_ctrl.sv
// pool_window_ctrl: raster-stream window sequencer for a PxP max-pooling unit.
module pool_window_ctrl #(
   parameter int M = 28,
   parameter int N = 28,
   parameter int P = 2,
   parameter int C = 1,
   parameter int LAT = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_start,
   input  logic                   i_data_valid,
   output logic                   o_ready,
   output logic                   o_pool_en,
   output logic [$clog2(M)-1:0]   o_col,
   output logic [$clog2(N)-1:0]   o_row,
   output logic [$clog2(C+1)-1:0] o_ch,
   output logic                   o_win_last,
   output logic                   o_out_valid,
   output logic                   o_busy,
   output logic                   o_done
);
   localparam int CW = $clog2(M);
   localparam int RW = $clog2(N);
   localparam int HW = $clog2(C+1);
   localparam int DW = $clog2(LAT+1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;
   logic [DW-1:0] dcnt;
   logic [LAT-1:0] dly;
   logic [31:0] col32, row32;
   logic col_end, row_end, ch_end;
   assign col_end = o_col == CW'(M-1);
   assign row_end = o_row == RW'(N-1);
   assign ch_end = o_ch == HW'(C-1);
   assign o_ready = state == RUN;
   assign o_busy = state != IDLE;
   assign o_done = state == DONE;
   assign o_pool_en = i_data_valid & o_ready;
   assign col32 = 32'(o_col);
   assign row32 = 32'(o_row);
   // Only full windows are flagged; right/bottom remainders are dropped.
   assign o_win_last = o_pool_en && (col32 % 32'(P) == 32'(P-1)) && (row32 % 32'(P) == 32'(P-1))
                       && (col32 < 32'((M/P)*P)) && (row32 < 32'((N/P)*P));
   assign o_out_valid = dly[LAT-1];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         o_col <= '0;
         o_row <= '0;
         o_ch <= '0;
         dcnt <= '0;
         dly <= '0;
      end else begin
         dly <= LAT'({dly, o_win_last});
         case (state)
            IDLE: if (i_start) begin
               state <= RUN;
               o_col <= '0;
               o_row <= '0;
               o_ch <= '0;
            end
            RUN: if (o_pool_en) begin
               o_col <= col_end ? '0 : o_col + 1'b1;
               if (col_end) begin
                  o_row <= row_end ? '0 : o_row + 1'b1;
                  if (row_end) begin
                     o_ch <= o_ch + 1'b1;
                     if (ch_end) begin
                        state <= DRAIN;
                        dcnt <= '0;
                     end
                  end
               end
            end
            DRAIN: begin
               state <= dcnt == DW'(LAT-1) ? DONE : DRAIN;
               dcnt <= dcnt + 1'b1;
            end
            DONE: state <= IDLE;
         endcase
      end
   end
endmodule
